// File: rtl/riscv_pkg.sv
// Shared encodings and helpers for the MEM-stage load/store unit.
// Holds the decode type codes, the LSU state enum and store lane-steering functions.
package riscv_pkg;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b011;
    localparam logic [2:0] LOAD_LHU = 3'b100;
    localparam logic [2:0] LOAD_DEF = 3'b111;

    localparam logic [1:0] STORE_SB  = 2'b00;
    localparam logic [1:0] STORE_SH  = 2'b01;
    localparam logic [1:0] STORE_SW  = 2'b10;
    localparam logic [1:0] STORE_DEF = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    // Access captured in IDLE and replayed unchanged on the bus until it completes.
    typedef struct packed {
        logic        we;
        logic [29:0] waddr;
        logic [1:0]  offset;
        logic [2:0]  ltype;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } lsu_req_t;

    function automatic logic load_misaligned(input logic [2:0] lt, input logic [1:0] off);
        case (lt)
            LOAD_LB, LOAD_LBU: load_misaligned = 1'b0;
            LOAD_LH, LOAD_LHU: load_misaligned = off[0];
            default:           load_misaligned = (off != 2'b00);
        endcase
    endfunction

    function automatic logic store_misaligned(input logic [1:0] st, input logic [1:0] off);
        case (st)
            STORE_SH: store_misaligned = off[0];
            STORE_SW: store_misaligned = (off != 2'b00);
            default:  store_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [1:0] st, input logic [1:0] off);
        case (st)
            STORE_SB: store_strb = 4'b0001 << off;
            STORE_SH: store_strb = 4'b0011 << {off[1], 1'b0};
            STORE_SW: store_strb = 4'b1111;
            default:  store_strb = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [1:0] st, input logic [31:0] sd);
        case (st)
            STORE_SB: store_wdata = {4{sd[7:0]}};
            STORE_SH: store_wdata = {2{sd[15:0]}};
            default:  store_wdata = sd;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_access_if.sv
// Data-memory request/grant/response bus between the LSU (master) and memory (slave).
interface lsu_mem_access_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/lsu_load_formatter.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module lsu_load_formatter
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  load_type,
    output logic [31:0] result
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'(rdata >> {offset, 3'b000});
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        case (load_type)
            LOAD_LB:  result = {{24{byte_sel[7]}}, byte_sel};
            LOAD_LH:  result = {{16{half_sel[15]}}, half_sel};
            LOAD_LBU: result = {24'h0, byte_sel};
            LOAD_LHU: result = {16'h0, half_sel};
            default:  result = rdata;
        endcase
    end
endmodule

// File: rtl/lsu_mem_access.sv
// MEM-stage load/store unit: runs one data-memory access per instruction, stalling the
// pipeline until grant (stores) or read data (loads) arrives, with a timeout watchdog.
module lsu_mem_access
    import riscv_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  mem_load_type,
    input  logic [1:0]  mem_store_type,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        bus_error,
    lsu_mem_access_if.master dmem
);
    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    lsu_state_e  state_q, state_d;
    lsu_req_t    req_q, req_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] load_data_q, load_data_d;
    logic        bus_error_q, bus_error_d;

    logic        is_wr, is_rd, access, mis, start;
    logic [31:0] fmt_data;

    lsu_load_formatter u_fmt (
        .rdata     (dmem.dmem_rdata),
        .offset    (req_q.offset),
        .load_type (req_q.ltype),
        .result    (fmt_data)
    );

    // A store wins over a simultaneous load; STORE_DEF with mem_write is a no-op.
    always_comb begin
        is_wr  = mem_write;
        is_rd  = mem_read && !mem_write;
        access = (is_wr && (mem_store_type != STORE_DEF)) || is_rd;
        mis    = is_wr ? store_misaligned(mem_store_type, addr[1:0])
                       : load_misaligned(mem_load_type, addr[1:0]);
        start  = (state_q == IDLE) && access && !mis;
    end

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        cnt_d       = cnt_q;
        load_data_d = load_data_q;
        bus_error_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    req_d.we     = is_wr;
                    req_d.waddr  = addr[31:2];
                    req_d.offset = addr[1:0];
                    req_d.ltype  = mem_load_type;
                    req_d.wstrb  = is_wr ? store_strb(mem_store_type, addr[1:0]) : 4'b0000;
                    req_d.wdata  = is_wr ? store_wdata(mem_store_type, store_data) : 32'h0;
                    cnt_d        = 8'd0;
                    state_d      = REQ;
                end
            end
            REQ: begin
                if (dmem.dmem_gnt) begin
                    cnt_d   = 8'd0;
                    state_d = req_q.we ? DONE : WAIT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == MAX_WAIT_C) begin
                        bus_error_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            WAIT: begin
                if (dmem.dmem_rvalid) begin
                    load_data_d = fmt_data;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == MAX_WAIT_C) begin
                        bus_error_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_q       <= '0;
            cnt_q       <= 8'd0;
            load_data_q <= 32'h0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            cnt_q       <= cnt_d;
            load_data_q <= load_data_d;
            bus_error_q <= bus_error_d;
        end
    end

    // Combinational IDLE-cycle outputs are gated so reset forces every output low.
    assign stall      = !rst && (start || (state_q == REQ) || (state_q == WAIT));
    assign misaligned = !rst && (state_q == IDLE) && access && mis;
    assign bus_error  = bus_error_q;
    assign load_data  = load_data_q;

    assign dmem.dmem_req   = (state_q == REQ);
    assign dmem.dmem_we    = req_q.we;
    assign dmem.dmem_addr  = {req_q.waddr, 2'b00};
    assign dmem.dmem_wstrb = req_q.wstrb;
    assign dmem.dmem_wdata = req_q.wdata;
endmodule

// File: tb/tb_lsu_mem_access.sv
// Self-checking bench for lsu_mem_access: directed vector table, randomized ops against a
// byte-level reference model, and reset-during-access sequences.
module tb_lsu_mem_access;
    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [2:0]  mem_load_type;
    logic [1:0]  mem_store_type;
    logic [31:0] addr, store_data;
    logic        stall, misaligned, bus_error;
    logic [31:0] load_data;

    lsu_mem_access_if dif ();

    lsu_mem_access #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_load_type(mem_load_type), .mem_store_type(mem_store_type),
        .addr(addr), .store_data(store_data), .stall(stall), .load_data(load_data),
        .misaligned(misaligned), .bus_error(bus_error), .dmem(dif)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rd, wr;
        logic [2:0] lt;
        logic [1:0] st;
        logic [31:0] a, sd, rdata;
        int gd, rvd;
        bit stray;
    } op_t;

    typedef struct {
        int stall;
        bit mis, berr, req;
        logic [31:0] addr;
        bit we;
        logic [3:0] wstrb;
        logic [31:0] wdata, ld;
    } exp_t;

    typedef struct {
        exp_t v;
        bit unstable, late, tmo;
    } obs_t;

    typedef struct {
        op_t  o;
        exp_t e;
    } vec_t;

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic op_t mk_op(bit rd, bit wr, logic [2:0] lt, logic [1:0] st, logic [31:0] a,
                                  logic [31:0] sd, logic [31:0] rdata, int gd, int rvd, bit stray);
        op_t o;
        o.rd = rd; o.wr = wr; o.lt = lt; o.st = st; o.a = a; o.sd = sd;
        o.rdata = rdata; o.gd = gd; o.rvd = rvd; o.stray = stray;
        return o;
    endfunction

    function automatic exp_t ex(int stall_n, bit mis, bit berr, bit req, logic [31:0] a, bit we,
                                logic [3:0] wstrb, logic [31:0] wdata, logic [31:0] ld);
        exp_t e;
        e.stall = stall_n; e.mis = mis; e.berr = berr; e.req = req; e.addr = a;
        e.we = we; e.wstrb = wstrb; e.wdata = wdata; e.ld = ld;
        return e;
    endfunction

    // Reference: access size in bytes, alignment by modulo, lanes by byte position,
    // stall length by counting the cycles each phase needs.
    function automatic exp_t model(input op_t o, input logic [31:0] prev);
        exp_t e;
        int size, off;
        bit acc, ld;
        logic [31:0] v;
        e = ex(0, 0, 0, 0, 0, 0, 0, 0, prev);
        acc = 0; ld = 0; size = 4;
        if (o.wr) begin
            acc  = (o.st != 2'd3);
            size = (o.st == 2'd0) ? 1 : (o.st == 2'd1) ? 2 : 4;
        end else if (o.rd) begin
            acc = 1; ld = 1;
            size = (o.lt == 3'd0 || o.lt == 3'd3) ? 1 : (o.lt == 3'd1 || o.lt == 3'd4) ? 2 : 4;
        end
        if (!acc) return e;
        off = int'(o.a[1:0]);
        if (off % size != 0) begin
            e.mis = 1;
            return e;
        end
        e.req = 1; e.addr = o.a & 32'hFFFF_FFFC; e.we = !ld;
        if (!ld)
            for (int i = 0; i < 4; i++) begin
                e.wstrb[i] = (i >= off) && (i < off + size);
                e.wdata[8*i +: 8] = o.sd[8*(i % size) +: 8];
            end
        if (o.gd >= MAXW) begin
            e.berr = 1; e.stall = 1 + MAXW;
            return e;
        end
        e.stall = 2 + o.gd;
        if (!ld) return e;
        if (o.rvd >= MAXW) begin
            e.berr = 1; e.stall += MAXW;
            return e;
        end
        e.stall += o.rvd + 1;
        v = o.rdata >> (8 * off);
        if (size == 1) begin
            v = v & 32'hFF;
            if (o.lt == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 2) begin
            v = v & 32'hFFFF;
            if (o.lt == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        end
        e.ld = v;
        return e;
    endfunction

    // Drives one op from an IDLE negedge and plays memory: grant after gd request cycles,
    // rvalid gd..rvd cycles later; optional stray rvalid in the grant cycle.
    task automatic run_op(input op_t o, output obs_t ob);
        int reqc, agc;
        bit granted;
        ob.v = ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
        ob.unstable = 0; ob.late = 0; ob.tmo = 1;
        reqc = 0; agc = 0; granted = 0;
        mem_read = o.rd; mem_write = o.wr; mem_load_type = o.lt; mem_store_type = o.st;
        addr = o.a; store_data = o.sd;
        #1;
        for (int c = 0; c < 40; c++) begin
            if (misaligned) ob.v.mis = 1;
            if (bus_error) ob.v.berr = 1;
            dif.dmem_gnt = 0; dif.dmem_rvalid = 0; dif.dmem_rdata = ~o.rdata;
            if (dif.dmem_req) begin
                if (!ob.v.req) begin
                    ob.v.req = 1; ob.v.addr = dif.dmem_addr; ob.v.we = dif.dmem_we;
                    ob.v.wstrb = dif.dmem_wstrb; ob.v.wdata = dif.dmem_wdata;
                end else if ({dif.dmem_addr, dif.dmem_we, dif.dmem_wstrb, dif.dmem_wdata} !==
                             {ob.v.addr, ob.v.we, ob.v.wstrb, ob.v.wdata}) begin
                    ob.unstable = 1;
                end
                if (reqc == o.gd) begin
                    dif.dmem_gnt = 1; granted = 1; dif.dmem_rvalid = o.stray;
                end
                reqc++;
            end else if (granted && stall) begin
                if (agc == o.rvd) begin
                    dif.dmem_rvalid = 1; dif.dmem_rdata = o.rdata;
                end
                agc++;
            end
            if (stall) ob.v.stall++;
            else begin
                ob.v.ld = load_data; ob.tmo = 0;
                break;
            end
            @(negedge clk);
        end
        mem_read = 0; mem_write = 0; dif.dmem_gnt = 0; dif.dmem_rvalid = 0;
        @(negedge clk);
        if (dif.dmem_req || stall) ob.late = 1;
    endtask

    task automatic cmp(input string tag, input obs_t o, input exp_t e);
        chk({tag, " bound"},    32'(o.tmo),     32'd0);
        chk({tag, " stall"},    32'(o.v.stall), 32'(e.stall));
        chk({tag, " misalign"}, 32'(o.v.mis),   32'(e.mis));
        chk({tag, " bus_err"},  32'(o.v.berr),  32'(e.berr));
        chk({tag, " req_seen"}, 32'(o.v.req),   32'(e.req));
        chk({tag, " load"},     o.v.ld,         e.ld);
        chk({tag, " idle_after"}, 32'(o.late),  32'd0);
        if (e.req) begin
            chk({tag, " addr"},   o.v.addr,        e.addr);
            chk({tag, " we"},     32'(o.v.we),     32'(e.we));
            chk({tag, " stable"}, 32'(o.unstable), 32'd0);
            if (e.we) begin
                chk({tag, " wstrb"}, 32'(o.v.wstrb), 32'(e.wstrb));
                chk({tag, " wdata"}, o.v.wdata,      e.wdata);
            end
        end
    endtask

    vec_t vt[15];
    logic [2:0] lts[6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
    logic [31:0] prev;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        op_t o; exp_t e; obs_t ob;
        rst = 1; mem_read = 1; mem_write = 0; mem_load_type = 3'd2; mem_store_type = 2'd0;
        addr = 32'h0; store_data = 32'h0;
        dif.dmem_gnt = 0; dif.dmem_rvalid = 0; dif.dmem_rdata = 0;
        @(negedge clk);
        chk("rst stall", 32'(stall), 0);
        chk("rst load_data", load_data, 0);
        chk("rst misaligned", 32'(misaligned), 0);
        chk("rst bus_error", 32'(bus_error), 0);
        chk("rst dmem_req", 32'(dif.dmem_req), 0);
        chk("rst dmem_we", 32'(dif.dmem_we), 0);
        chk("rst dmem_addr", dif.dmem_addr, 0);
        chk("rst dmem_wstrb", 32'(dif.dmem_wstrb), 0);
        chk("rst dmem_wdata", dif.dmem_wdata, 0);
        mem_read = 0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);

        vt[0]  = '{mk_op(0,1,3'd0,2'd0,32'h1003,32'hA5,0,0,0,0),
                   ex(2,0,0,1,32'h1000,1,4'b1000,32'hA5A5A5A5,0)};
        vt[1]  = '{mk_op(1,0,3'd0,2'd3,32'h2001,0,32'h000080FF,0,0,0),
                   ex(3,0,0,1,32'h2000,0,0,0,32'hFFFFFF80)};
        vt[2]  = '{mk_op(1,0,3'd3,2'd3,32'h2001,0,32'h000080FF,0,0,0),
                   ex(3,0,0,1,32'h2000,0,0,0,32'h00000080)};
        vt[3]  = '{mk_op(1,0,3'd4,2'd3,32'h3002,0,32'hBEEF1234,3,0,0),
                   ex(6,0,0,1,32'h3000,0,0,0,32'h0000BEEF)};
        vt[4]  = '{mk_op(1,0,3'd2,2'd3,32'h4002,0,32'h11111111,0,0,0),
                   ex(0,1,0,0,0,0,0,0,32'h0000BEEF)};
        vt[5]  = '{mk_op(1,0,3'd2,2'd3,32'h5000,0,32'h22222222,0,99,0),
                   ex(6,0,1,1,32'h5000,0,0,0,32'h0000BEEF)};
        vt[6]  = '{mk_op(0,1,3'd0,2'd1,32'h6002,32'h1234ABCD,0,0,0,0),
                   ex(2,0,0,1,32'h6000,1,4'b1100,32'hABCDABCD,32'h0000BEEF)};
        vt[7]  = '{mk_op(0,1,3'd0,2'd2,32'h7000,32'hDEADBEEF,0,1,0,0),
                   ex(3,0,0,1,32'h7000,1,4'b1111,32'hDEADBEEF,32'h0000BEEF)};
        vt[8]  = '{mk_op(0,1,3'd0,2'd3,32'h7004,32'h55555555,0,0,0,0),
                   ex(0,0,0,0,0,0,0,0,32'h0000BEEF)};
        vt[9]  = '{mk_op(1,0,3'd1,2'd3,32'h8002,0,32'h80010000,0,0,1),
                   ex(3,0,0,1,32'h8000,0,0,0,32'hFFFF8001)};
        vt[10] = '{mk_op(1,1,3'd2,2'd0,32'h9001,32'h0000005A,0,0,0,0),
                   ex(2,0,0,1,32'h9000,1,4'b0010,32'h5A5A5A5A,32'hFFFF8001)};
        vt[11] = '{mk_op(1,0,3'd0,2'd3,32'hA003,0,32'h33333333,5,0,0),
                   ex(5,0,1,1,32'hA000,0,0,0,32'hFFFF8001)};
        vt[12] = '{mk_op(1,0,3'd7,2'd3,32'hB000,0,32'h12345678,0,2,0),
                   ex(5,0,0,1,32'hB000,0,0,0,32'h12345678)};
        vt[13] = '{mk_op(1,0,3'd4,2'd3,32'hC001,0,32'h44444444,0,0,0),
                   ex(0,1,0,0,0,0,0,0,32'h12345678)};
        vt[14] = '{mk_op(0,1,3'd0,2'd2,32'hC002,32'h66666666,0,0,0,0),
                   ex(0,1,0,0,0,0,0,0,32'h12345678)};

        for (int i = 0; i < 15; i++) begin
            run_op(vt[i].o, ob);
            cmp($sformatf("vec%0d", i), ob, vt[i].e);
        end
        prev = vt[14].e.ld;

        for (int i = 0; i < 80; i++) begin
            o.wr = ($urandom_range(0, 9) < 4);
            o.rd = !o.wr || ($urandom_range(0, 7) == 0);
            o.lt = lts[$urandom_range(0, 5)];
            o.st = 2'($urandom_range(0, 3));
            o.a = $urandom;
            if ($urandom_range(0, 2) != 0) o.a[1:0] = 2'b00;
            o.sd = $urandom;
            o.rdata = $urandom;
            o.gd = ($urandom_range(0, 9) == 0) ? MAXW + $urandom_range(0, 2) : $urandom_range(0, 3);
            o.rvd = ($urandom_range(0, 9) == 0) ? MAXW + $urandom_range(0, 2) : $urandom_range(0, 3);
            o.stray = 1'($urandom_range(0, 1));
            e = model(o, prev);
            run_op(o, ob);
            cmp($sformatf("rnd%0d", i), ob, e);
            prev = e.ld;
        end

        // Make sure load_data is nonzero so the reset clearing it is observable.
        run_op(mk_op(1,0,3'd2,2'd3,32'hD000,0,32'hCAFEF00D,0,0,0), ob);
        cmp("preload", ob, model(mk_op(1,0,3'd2,2'd3,32'hD000,0,32'hCAFEF00D,0,0,0), prev));

        // Reset while waiting for read data, then a stray rvalid after release.
        mem_read = 1; mem_write = 0; mem_load_type = 3'd2; addr = 32'hE000;
        @(negedge clk);
        chk("rstseq req", 32'(dif.dmem_req), 1);
        dif.dmem_gnt = 1;
        @(negedge clk);
        dif.dmem_gnt = 0;
        chk("rstseq wait stall", 32'(stall), 1);
        chk("rstseq wait req", 32'(dif.dmem_req), 0);
        rst = 1;
        #1;
        chk("rstseq rst stall", 32'(stall), 0);
        chk("rstseq rst req", 32'(dif.dmem_req), 0);
        chk("rstseq rst load", load_data, 0);
        chk("rstseq rst addr", dif.dmem_addr, 0);
        @(negedge clk);
        rst = 0; mem_read = 0;
        @(negedge clk);
        dif.dmem_rvalid = 1; dif.dmem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        dif.dmem_rvalid = 0;
        @(negedge clk);
        chk("rstseq stray load", load_data, 0);
        chk("rstseq stray stall", 32'(stall), 0);
        chk("rstseq stray req", 32'(dif.dmem_req), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
